// File: rtl/dco_ctrl_pkg.sv
// rtl/dco_ctrl_pkg.sv - shared types and constants for the DCO code controller
package dco_ctrl_pkg;

    localparam int CODE_W = 7;
    localparam int N_TAPS = 128;

    localparam logic [CODE_W-1:0] SEARCH_START = 7'd64;
    localparam logic [CODE_W-1:0] SEARCH_STEP0 = 7'd32;
    localparam logic [CODE_W-1:0] CODE_MAX     = 7'd127;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        TRACK,
        LOCK
    } dco_state_e;

endpackage

// File: rtl/dco_therm_enc.sv
// rtl/dco_therm_enc.sv - combinational 7-bit code to 128-tap thermometer decode
module dco_therm_enc
    import dco_ctrl_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [N_TAPS-1:0] therm
);

    // Tap 0 is always on, so code 0 still drives one stage.
    always_comb begin
        therm = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            therm[i] = (CODE_W'(i) <= code);
        end
    end

endmodule

// File: rtl/dco_code_ctrl.sv
// rtl/dco_code_ctrl.sv - ADPLL DCO code loop: SAR coarse search, +/-1 tracking, lock (option: DCO_CTRL_MANUAL_EN)
module dco_code_ctrl
    import dco_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int LOCK_CNT   = 8
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              start,
    input  logic              up,
    input  logic              dn,
`ifdef DCO_CTRL_MANUAL_EN
    input  logic              man_en,
    input  logic [CODE_W-1:0] man_code,
`endif
    output logic [CODE_W-1:0] code,
    output logic [N_TAPS-1:0] therm,
    output logic              dco_en,
    output logic              busy,
    output logic              locked
);

    dco_state_e        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [N_TAPS-1:0] therm_q, therm_d;
    logic [CODE_W-1:0] step_q, step_d;
    logic [7:0]        settle_q, settle_d;
    logic [7:0]        rev_q, rev_d;
    logic              dir_valid_q, dir_valid_d;
    logic              dir_up_q, dir_up_d;
    logic              dco_en_q, dco_en_d;
    logic              busy_q, busy_d;
    logic              locked_q, locked_d;

    logic       mv_up, mv_dn, window_done, same_dir, rev_dir;
    logic [7:0] rev_inc;

    assign mv_up       = up & ~dn;
    assign mv_dn       = dn & ~up;
    assign window_done = (settle_q == 8'(SETTLE_CYC));
    assign same_dir    = dir_valid_q & (dir_up_q == mv_up);
    assign rev_dir     = dir_valid_q & (dir_up_q != mv_up);
    assign rev_inc     = rev_q + 8'd1;

    // therm is decoded from the next code so both registers change together.
    dco_therm_enc u_therm_enc (
        .code  (code_d),
        .therm (therm_d)
    );

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        step_d      = step_q;
        settle_d    = settle_q;
        rev_d       = rev_q;
        dir_valid_d = dir_valid_q;
        dir_up_d    = dir_up_q;
        dco_en_d    = dco_en_q;
        busy_d      = busy_q;
        locked_d    = locked_q;

        if (!start) begin
            state_d  = IDLE;
            dco_en_d = 1'b0;
            busy_d   = 1'b0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = SEARCH;
                    code_d      = SEARCH_START;
                    step_d      = SEARCH_STEP0;
                    settle_d    = '0;
                    rev_d       = '0;
                    dir_valid_d = 1'b0;
                    dco_en_d    = 1'b1;
                    busy_d      = 1'b1;
                    locked_d    = 1'b0;
                end
                SEARCH: begin
                    if (!window_done) begin
                        settle_d = settle_q + 8'd1;
                    end else begin
                        settle_d = '0;
                        code_d   = mv_up ? code_q + step_q : code_q - step_q;
                        step_d   = step_q >> 1;
                        if (step_q == 7'd1) begin
                            state_d     = TRACK;
                            busy_d      = 1'b0;
                            rev_d       = '0;
                            dir_valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    if (!window_done) begin
                        settle_d = settle_q + 8'd1;
                    end else begin
                        settle_d = '0;
                        if (mv_up || mv_dn) begin
                            // A saturated request still registers as a move.
                            if (mv_up && code_q != CODE_MAX) code_d = code_q + 7'd1;
                            if (mv_dn && code_q != '0)       code_d = code_q - 7'd1;
                            dir_valid_d = 1'b1;
                            dir_up_d    = mv_up;
                            if (state_q == TRACK) begin
                                if (same_dir) begin
                                    rev_d = '0;
                                end else if (rev_dir) begin
                                    rev_d = rev_inc;
                                    if (rev_inc == 8'(LOCK_CNT)) begin
                                        state_d  = LOCK;
                                        locked_d = 1'b1;
                                    end
                                end
                            end else if (same_dir) begin
                                state_d  = TRACK;
                                locked_d = 1'b0;
                                rev_d    = '0;
                            end
                        end
                    end
                end
            endcase
        end

`ifdef DCO_CTRL_MANUAL_EN
        if (man_en) begin
            state_d  = IDLE;
            code_d   = man_code;
            settle_d = '0;
            dco_en_d = 1'b1;
            busy_d   = 1'b0;
            locked_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            state_q     <= IDLE;
            code_q      <= '0;
            therm_q     <= {{(N_TAPS-1){1'b0}}, 1'b1};
            step_q      <= SEARCH_STEP0;
            settle_q    <= '0;
            rev_q       <= '0;
            dir_valid_q <= 1'b0;
            dir_up_q    <= 1'b0;
            dco_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            therm_q     <= therm_d;
            step_q      <= step_d;
            settle_q    <= settle_d;
            rev_q       <= rev_d;
            dir_valid_q <= dir_valid_d;
            dir_up_q    <= dir_up_d;
            dco_en_q    <= dco_en_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
        end
    end

    assign code   = code_q;
    assign therm  = therm_q;
    assign dco_en = dco_en_q;
    assign busy   = busy_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_dco_code_ctrl.sv
// tb/tb_dco_code_ctrl.sv - self-checking bench for dco_code_ctrl against a behavioural loop model
module tb_dco_code_ctrl;

    localparam int SETTLE_CYC = 4;
    localparam int LOCK_CNT   = 8;
    localparam int WIN        = SETTLE_CYC + 1;

    localparam int P_IDLE   = 0;
    localparam int P_SEARCH = 1;
    localparam int P_TRACK  = 2;
    localparam int P_LOCK   = 3;

    logic         clk = 1'b0;
    logic         reset_;
    logic         start, up, dn;
    logic [6:0]   code;
    logic [127:0] therm;
    logic         dco_en, busy, locked;
`ifdef DCO_CTRL_MANUAL_EN
    logic         man_en = 1'b0;
    logic [6:0]   man_code = 7'd0;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    dco_code_ctrl #(.SETTLE_CYC(SETTLE_CYC), .LOCK_CNT(LOCK_CNT)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .start    (start),
        .up       (up),
        .dn       (dn),
`ifdef DCO_CTRL_MANUAL_EN
        .man_en   (man_en),
        .man_code (man_code),
`endif
        .code     (code),
        .therm    (therm),
        .dco_en   (dco_en),
        .busy     (busy),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    // Behavioural model: decisions happen at absolute cycle numbers.
    int m_cyc, m_next, m_phase, m_code, m_step, m_prev, m_rev;
    bit m_en, m_busy, m_locked;

    function automatic logic [127:0] therm_of(input int c);
        logic [127:0] ones;
        ones = '1;
        return ones >> (127 - c);
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(posedge clk or posedge reset_) begin
        if (reset_) begin
            m_phase = P_IDLE; m_code = 0; m_step = 32; m_prev = 0; m_rev = 0;
            m_en = 0; m_busy = 0; m_locked = 0; m_cyc = 0; m_next = 0;
        end else begin
            int d;
            m_cyc++;
            d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
            if (!start) begin
                m_phase = P_IDLE; m_en = 0; m_busy = 0; m_locked = 0;
            end else if (m_phase == P_IDLE) begin
                m_phase = P_SEARCH; m_code = 64; m_step = 32; m_prev = 0; m_rev = 0;
                m_en = 1; m_busy = 1; m_locked = 0; m_next = m_cyc + WIN;
            end else if (m_cyc == m_next) begin
                m_next = m_cyc + WIN;
                if (m_phase == P_SEARCH) begin
                    m_code += (d == 1) ? m_step : -m_step;
                    if (m_step == 1) begin
                        m_phase = P_TRACK; m_busy = 0; m_prev = 0; m_rev = 0;
                    end
                    m_step /= 2;
                end else if (d != 0) begin
                    if (d == 1 && m_code < 127) m_code++;
                    if (d == -1 && m_code > 0) m_code--;
                    if (m_phase == P_TRACK) begin
                        if (m_prev == d) m_rev = 0;
                        else if (m_prev != 0) begin
                            m_rev++;
                            if (m_rev == LOCK_CNT) begin m_phase = P_LOCK; m_locked = 1; end
                        end
                    end else if (m_prev == d) begin
                        m_phase = P_TRACK; m_locked = 0; m_rev = 0;
                    end
                    m_prev = d;
                end
            end
`ifdef DCO_CTRL_MANUAL_EN
            if (man_en) begin
                m_phase = P_IDLE; m_code = int'(man_code); m_en = 1; m_busy = 0; m_locked = 0;
            end
`endif
        end
    end

    always @(negedge clk) begin
        check("code", 128'(code), 128'(m_code));
        check("therm", therm, therm_of(m_code));
        check("dco_en", 128'(dco_en), 128'(m_en));
        check("busy", 128'(busy), 128'(m_busy));
        check("locked", 128'(locked), 128'(m_locked));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_dir(input int d);
        up = (d == 1);
        dn = (d == -1);
    endtask

    initial begin
        int up_codes[7];
        int dn_codes[7];
        int moves[10];
        up_codes = '{64, 96, 112, 120, 124, 126, 127};
        dn_codes = '{64, 32, 16, 8, 4, 2, 1};
        moves    = '{-1, 1, -1, 1, -1, 0, 1, -1, 1, -1};

        reset_ = 1'b0; start = 1'b0; up = 1'b0; dn = 1'b0;
        #1 reset_ = 1'b1;
        #1;
        check("rst_code", 128'(code), 128'd0);
        check("rst_therm", therm, 128'h1);
        check("rst_dco_en", 128'(dco_en), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_locked", 128'(locked), 128'd0);
        tick(2);
        reset_ = 1'b0;
        tick(2);

        // Coarse search with up held: climbs to 127 and saturates there.
        start = 1'b1; set_dir(1);
        tick(1);
        check("up_e0_code", 128'(code), 128'd64);
        check("up_e0_busy", 128'(busy), 128'd1);
        check("up_e0_en", 128'(dco_en), 128'd1);
        for (int k = 1; k <= 6; k++) begin
            tick(WIN);
            check("up_search_code", 128'(code), 128'(up_codes[k]));
            if (k == 5) check("up_busy_before", 128'(busy), 128'd1);
        end
        check("up_busy_fall", 128'(busy), 128'd0);
        tick(2 * WIN);
        check("up_sat_code", 128'(code), 128'd127);
        check("up_sat_therm", therm, '1);
        start = 1'b0;
        tick(1);
        check("stop_en", 128'(dco_en), 128'd0);
        check("stop_code_held", 128'(code), 128'd127);

        // Coarse search with dn held: down to 1, then tracking floors at 0.
        start = 1'b1; set_dir(-1);
        tick(1);
        check("dn_e0_code", 128'(code), 128'd64);
        for (int k = 1; k <= 6; k++) begin
            tick(WIN);
            check("dn_search_code", 128'(code), 128'(dn_codes[k]));
        end
        tick(WIN);
        check("dn_track_code", 128'(code), 128'd0);
        tick(2 * WIN);
        check("dn_sat_code", 128'(code), 128'd0);
        check("dn_sat_therm", therm, 128'h1);
        start = 1'b0;
        tick(1);

        // Random search, then alternating windows with one hold in between.
        start = 1'b1;
        tick(1);
        for (int i = 0; i < 6 * WIN; i++) begin
            up = 1'($urandom); dn = 1'($urandom);
            tick(1);
        end
        check("trk_busy", 128'(busy), 128'd0);
        foreach (moves[i]) begin
            if (i == 9) check("pre_lock", 128'(locked), 128'd0);
            set_dir(moves[i]);
            tick(WIN);
        end
        check("lock_rise", 128'(locked), 128'd1);
        set_dir(1);
        tick(WIN);
        check("lock_first_up", 128'(locked), 128'd1);
        tick(WIN);
        check("lock_second_up", 128'(locked), 128'd0);
        check("unlock_en", 128'(dco_en), 128'd1);
        start = 1'b0;
        tick(1);
        check("drop_en", 128'(dco_en), 128'd0);
        check("drop_locked", 128'(locked), 128'd0);

        // Asynchronous reset in the middle of a search.
        start = 1'b1;
        tick(1 + 8);
        reset_ = 1'b1;
        #1;
        check("arst_code", 128'(code), 128'd0);
        check("arst_therm", therm, 128'h1);
        check("arst_en", 128'(dco_en), 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        tick(1);
        reset_ = 1'b0;
        start = 1'b0;
        tick(2);

`ifdef DCO_CTRL_MANUAL_EN
        man_en = 1'b1; man_code = 7'd37;
        tick(1);
        check("man_code", 128'(code), 128'd37);
        check("man_therm", therm, 128'h0000_0000_0000_0000_0000_003f_ffff_ffff);
        check("man_en", 128'(dco_en), 128'd1);
        check("man_locked", 128'(locked), 128'd0);
        man_en = 1'b0;
        tick(2);
`endif

        // Random soak, biased towards alternating directions so lock is reachable.
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) < 8) set_dir(((i / WIN) % 2 == 0) ? 1 : -1);
            else begin up = 1'($urandom); dn = 1'($urandom); end
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
